ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per request to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It implements the full inhibit → request-to-send → device-clocked shift → ACK sequence. It drives the shared PS/2 clock and data lines through open-drain enables, alongside the existing scan-code receive path. `busy` lets the system ignore receive traffic during a transmission.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency, documentation only.
- `INHIBIT_CYCLES`, default 5000: length of the host clock-inhibit phase (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: 15 ms transfer timeout, counted from entry to DATA.
- `FILTER_LEN`, default 8: consecutive equal samples required before the filtered ps2_clk changes.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `tx_data`  in  8: command byte; sampled on acceptance.
- `tx_valid`  in  1: request to send.
- `tx_ready`  out  1: high only in IDLE; a transfer is accepted on `tx_valid && tx_ready`.
- `ps2_clk_in`  in  1: raw PS/2 clock line level (asynchronous).
- `ps2_data_in`  in  1: raw PS/2 data line level (asynchronous).
- `ps2_clk_oe`  out  1: 1 = pull the clock line low; 0 = release it.
- `ps2_data_oe`  out  1: 1 = pull the data line low; 0 = release it.
- `busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse when the device acknowledged the byte.
- `tx_error`  out  1: one-cycle pulse on NACK or timeout.

## Operation
- Input conditioning:
  - Both `ps2_*_in` pass through a 2-flop synchronizer.
  - The clock is then filtered: the filtered value changes only after `FILTER_LEN` identical consecutive synchronized samples.
  - A falling edge is filtered 1→0; it produces a one-cycle `fall` strobe.
- State machine:
  - **IDLE**: both oe=0. On acceptance, latch `tx_data`, compute the odd parity bit p = ~^tx_data, clear the edge count, then go to INHIBIT.
  - **INHIBIT**: clk_oe=1, data_oe=0 for `INHIBIT_CYCLES` cycles, then RTS.
  - **RTS**: clk_oe=1, data_oe=1 (start bit) for exactly 1 cycle, then DATA.
  - **DATA**:
    - clk_oe=0. Clear the timeout counter on entry.
    - On each `fall`, increment the edge count n and update data_oe.
    - For n = 1..8, data_oe = ~byte[n-1], LSB first.
    - For n = 9, data_oe = ~p.
    - For n = 10, data_oe = 0 (stop bit, line released).
    - For n = 11, sample the synchronized `ps2_data_in`: 0 goes to WAIT_IDLE, 1 (NACK) goes to FAIL.
  - **WAIT_IDLE**: wait until the filtered clock = 1 and the synchronized data = 1. Then pulse `tx_done` and go to IDLE.
  - **FAIL**: both oe=0; pulse `tx_error`; go to IDLE.
- Timeout: in DATA or WAIT_IDLE, reaching `TIMEOUT_CYCLES` goes to FAIL. Timeout takes priority over a `fall` in the same cycle.
- `fall` strobes during INHIBIT or RTS are ignored; the host is driving the clock then.
- `tx_valid` while `tx_ready`=0 is ignored. Nothing is queued.
- Reset at any point: next cycle both oe=0, state IDLE, counters and the latched byte cleared.

## Timing
- Reset values:
  - `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `tx_done`=0, `tx_error`=0.
  - `tx_ready`=1 from the first cycle after reset.
- All outputs are registered. For acceptance at cycle 0:
  - At cycle 1, clk_oe=1 and busy=1.
  - At cycle 1+`INHIBIT_CYCLES`, data_oe=1.
  - One cycle later, clk_oe=0.
- A data_oe update follows a physical falling clock edge by at most 2+`FILTER_LEN`+1 clk cycles. That is ≤0.22 µs at defaults, well inside the device's ≥15 µs half-period.
- `tx_done` and `tx_error` are mutually exclusive. Each is exactly one cycle wide, concurrent with the return to IDLE. `tx_ready` rises the cycle after.

## Configuration
- `PS2_HOST_TX_RETRY_EN` defined:
  - On NACK or timeout, the block restarts from INHIBIT with the same byte, up to 2 retries (3 attempts total).
  - `tx_error` pulses only after the third failure; `busy` stays high throughout.
- `PS2_HOST_TX_RETRY_EN` undefined: the first failure goes to FAIL directly.

## Test plan
Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=4. The device model clocks at 40-cycle half-periods.
- Send 0xED with the device ACKing → the device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1. `tx_done` pulses once, `tx_error` never.
- Send 0x01 and 0x00 → parity 0 and 1 respectively. INHIBIT lasts exactly 20 cycles; RTS has both oe=1 for exactly 1 cycle.
- Device returns ACK=1 → `tx_error` one pulse, both oe=0.
  - With `PS2_HOST_TX_RETRY_EN`: 3 inhibit phases are seen before `tx_error`.
- Device never clocks → `tx_error` exactly 2000 cycles after DATA entry. `tx_ready`=1 the next cycle.
- Glitch of 3 low cycles on `ps2_clk_in` during DATA → no edge counted. The byte still transfers correctly.
- Assert rst after edge 5 → next cycle both oe=0, busy=0, tx_ready=1. A fresh 0xFF then transfers and ACKs.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte per request, for
// example 0xED (set LEDs) or 0xFF (reset). Each transfer runs through four
// phases: clock inhibit, request-to-send, device-clocked shift, and ACK
// check. The shared PS/2 lines are driven through open-drain enables, so
// this block sits beside the existing scan-code receiver on the same pins.
//
// Parameters:
//   CLK_FREQ_HZ    system clock frequency (documentation only)
//   INHIBIT_CYCLES length of the host clock-inhibit phase
//   TIMEOUT_CYCLES transfer timeout, counted from entry to the shift phase
//   FILTER_LEN     consecutive equal samples needed to change filtered clock
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   tx_data      command byte, captured when the request is accepted
//   tx_valid     request to send
//   tx_ready     high only while idle; accept on tx_valid && tx_ready
//   ps2_clk_in   raw PS/2 clock line level (asynchronous)
//   ps2_data_in  raw PS/2 data line level (asynchronous)
//   ps2_clk_oe   1 = pull the clock line low, 0 = release
//   ps2_data_oe  1 = pull the data line low, 0 = release
//   busy         high whenever a transfer is in progress
//   tx_done      one-cycle pulse: device acknowledged the byte
//   tx_error     one-cycle pulse: NACK or timeout
//
// Build option:
//   PS2_HOST_TX_RETRY_EN  when defined, a NACK or timeout restarts the
//                         transfer from the inhibit phase with the same byte,
//                         up to 2 retries; tx_error only after the third
//                         failed attempt.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  // The clock frequency only documents what INHIBIT/TIMEOUT mean in time.
  if (CLK_FREQ_HZ <= 0) begin : g_clk_freq_unset
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_WAIT_IDLE,
    S_FAIL
  } state_t;

  // Synchronizers and clock filter
  logic             clk_meta_q, clk_sync_q;
  logic             dat_meta_q, dat_sync_q;
  logic             flt_clk_q, flt_clk_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             fall;

  // Transfer control
  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_n_q, bit_n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             attempt_fail;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Filter: count consecutive synchronized samples that disagree with the
  // filtered level; flip only once FILTER_LEN of them have been seen.
  always_comb begin
    flt_clk_d = flt_clk_q;
    flt_cnt_d = '0;
    if (clk_sync_q != flt_clk_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        flt_clk_d = clk_sync_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  // Strobe in the same cycle the filtered clock commits to 0.
  assign fall = flt_clk_q & ~flt_clk_d;

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    parity_d     = parity_q;
    bit_n_d      = bit_n_q;
    cnt_d        = cnt_q;
    clk_oe_d     = clk_oe_q;
    data_oe_d    = data_oe_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    attempt_fail = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d      = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          byte_d   = tx_data;
          parity_d = ~^tx_data;
          bit_n_d  = '0;
          cnt_d    = '0;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d  = '0;
`endif
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Start bit is already on the data line; release the clock so the
      // device can begin clocking.
      S_RTS: begin
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        state_d  = S_DATA;
      end

      S_DATA: begin
        if (cnt_q == TMO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fall) begin
            bit_n_d = bit_n_q + 4'd1;
            // bit_n_q is the edge count before this fall, so bit_n_q 0..7
            // selects byte bit 0..7 for edges 1..8.
            if (bit_n_q < 4'd8) begin
              data_oe_d = ~byte_q[bit_n_q[2:0]];
            end else if (bit_n_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else if (bit_n_q == 4'd9) begin
              data_oe_d = 1'b0;
            end else if (dat_sync_q) begin
              attempt_fail = 1'b1;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end
        end
      end

      S_WAIT_IDLE: begin
        if (cnt_q == TMO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (flt_clk_q && dat_sync_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_FAIL: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    if (attempt_fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        cnt_d     = '0;
        bit_n_d   = '0;
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        state_d   = S_INHIBIT;
      end else begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        error_d   = 1'b1;
        state_d   = S_FAIL;
      end
`else
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
      state_d   = S_FAIL;
`endif
    end
  end

  assign busy_d  = (state_d != S_IDLE);
  // Hold ready low during the tx_done cycle so it rises one cycle later.
  assign ready_d = (state_d == S_IDLE) && !done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      flt_clk_q  <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= S_IDLE;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      bit_n_q    <= '0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data_in;
      dat_sync_q <= dat_meta_q;
      flt_clk_q  <= flt_clk_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      bit_n_q    <= bit_n_d;
      cnt_q      <= cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx with INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000,
// FILTER_LEN=4. A behavioural keyboard drives the open-drain bus with
// 40-cycle clock half-periods, samples data on rising clock edges and
// answers with ACK or NACK. Expected frames come from plain arithmetic on
// the command byte (LSB-first data, odd parity, stop bit).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int FLT  = 4;
  localparam int HALF = 40;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  // Cycles from acceptance to tx_error when the device never clocks.
  localparam int ERR_AT = (INH + 2) + (ATTEMPTS - 1) * (TMO + INH + 1) + TMO;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ   (50_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Event monitor: pulse counts, inhibit-phase starts, state at pulses.
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0;
  logic       prev_clk_oe = 1'b0, prev_pulse = 1'b0;
  logic       done_ready = 1'b0, ready_after = 1'b0;
  logic [1:0] err_oe = 2'b00;

  always @(negedge clk) begin
    prev_clk_oe <= ps2_clk_oe;
    if (ps2_clk_oe && !prev_clk_oe) inh_cnt <= inh_cnt + 1;
    if (tx_done) begin
      done_cnt   <= done_cnt + 1;
      done_ready <= tx_ready;
    end
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_oe  <= {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    prev_pulse <= tx_done | tx_error;
    if (prev_pulse) ready_after <= tx_ready;
  end

  // Reference frame as the device should sample it: data LSB first,
  // odd parity, stop bit 1.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic start_tx(input logic [7:0] b, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 5000);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard model. Waits for the host request (clock released, start bit
  // on data), then issues 11 clock pulses. abort_at>0 stops after that fall.
  task automatic device_xfer(input bit nack, input bit glitch, input int abort_at,
                             output logic [9:0] bits, output bit ok);
    int w;
    ok   = 1'b1;
    bits = '0;
    w    = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) ok = 1'b0;
    else begin
      repeat (HALF) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
        dev_clk_low = 1'b1;
        if (i == abort_at) begin
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b0;
          break;
        end
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) bits[i-1] = ps2_data_line;
        if (i == 10 && !nack) dev_data_low = 1'b1;
        if (i == 11) dev_data_low = 1'b0;
        if (glitch && i == 4) begin
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (3) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF - 13) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_end(input int base, output bit ok);
    int w;
    w = 0;
    while (done_cnt + err_cnt <= base && w < 4000) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 4000);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, want 00000",
               {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error});
    end
    n_vec++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, want 1", tx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({tx_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL post_reset_idle: ready,busy got %b, want 10", {tx_ready, busy});
    end
  endtask

  task automatic test_ack_ed();
    logic [9:0] got;
    bit ok_s, ok_d, ok_w;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      start_tx(8'hED, ok_s);
      device_xfer(1'b0, 1'b0, 0, got, ok_d);
    join
    wait_end(d0 + e0, ok_w);
    n_vec++;
    if ({ok_s, ok_d, ok_w} !== 3'b111) begin
      n_bad++;
      $display("FAIL ed_handshake: flags got %b, want 111", {ok_s, ok_d, ok_w});
    end
    n_vec++;
    if (got !== exp_frame(8'hED)) begin
      n_bad++;
      $display("FAIL ed_frame: got %b, want %b", got, exp_frame(8'hED));
    end
    n_vec++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_bad++;
      $display("FAIL ed_pulses: done %0d err %0d, want 1 and 0", done_cnt - d0, err_cnt - e0);
    end
    n_vec++;
    if ({done_ready, ready_after} !== 2'b01) begin
      n_bad++;
      $display("FAIL ed_ready_after_done: got %b, want 01", {done_ready, ready_after});
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [5];
    logic [9:0] got;
    logic [2:0] exp;
    bit ok_s, ok_d, ok_w;
    int d0, e0;
    bytes[0] = 8'h01;
    bytes[1] = 8'h00;
    for (int k = 2; k < 5; k++) bytes[k] = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      fork
        begin
          start_tx(bytes[k], ok_s);
          // Now at cycle 1 after acceptance: inhibit, one RTS cycle, release.
          if (k == 0) begin
            for (int c = 1; c <= INH + 2; c++) begin
              exp = {1'b1, (c <= INH + 1) ? 1'b1 : 1'b0, (c >= INH + 1) ? 1'b1 : 1'b0};
              n_vec++;
              if ({busy, ps2_clk_oe, ps2_data_oe} !== exp) begin
                n_bad++;
                $display("FAIL rts_timing cycle %0d: busy,clk_oe,data_oe got %b, want %b",
                         c, {busy, ps2_clk_oe, ps2_data_oe}, exp);
              end
              @(negedge clk);
            end
          end
        end
        device_xfer(1'b0, 1'b0, 0, got, ok_d);
      join
      wait_end(d0 + e0, ok_w);
      n_vec++;
      if ({ok_s, ok_d, ok_w} !== 3'b111 || got !== exp_frame(bytes[k])) begin
        n_bad++;
        $display("FAIL parity_frame byte %h: got %b, want %b (flags %b)",
                 bytes[k], got, exp_frame(bytes[k]), {ok_s, ok_d, ok_w});
      end
      n_vec++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
        n_bad++;
        $display("FAIL parity_pulses byte %h: done %0d err %0d, want 1 and 0",
                 bytes[k], done_cnt - d0, err_cnt - e0);
      end
    end
  endtask

  task automatic test_nack();
    logic [9:0] got;
    logic [7:0] b;
    bit ok_s, ok_d, ok_w;
    int d0, e0, i0;
    b  = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
    ok_d = 1'b1;
    fork
      start_tx(b, ok_s);
      begin
        for (int a = 0; a < ATTEMPTS; a++) begin
          bit ok_a;
          device_xfer(1'b1, 1'b0, 0, got, ok_a);
          if (!ok_a) ok_d = 1'b0;
        end
      end
    join
    wait_end(d0 + e0, ok_w);
    n_vec++;
    if ({ok_s, ok_d, ok_w} !== 3'b111 || got !== exp_frame(b)) begin
      n_bad++;
      $display("FAIL nack_frame: got %b, want %b (flags %b)", got, exp_frame(b), {ok_s, ok_d, ok_w});
    end
    n_vec++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL nack_pulses: err %0d done %0d, want 1 and 0", err_cnt - e0, done_cnt - d0);
    end
    n_vec++;
    if (inh_cnt - i0 !== ATTEMPTS) begin
      n_bad++;
      $display("FAIL nack_inhibit_phases: got %0d, want %0d", inh_cnt - i0, ATTEMPTS);
    end
    n_vec++;
    if ({err_oe, ready_after} !== 3'b001) begin
      n_bad++;
      $display("FAIL nack_oe_ready: oe at error %b ready after %b, want 00 and 1", err_oe, ready_after);
    end
    n_vec++;
    if (both_cnt !== 0) begin
      n_bad++;
      $display("FAIL done_error_overlap: got %0d, want 0", both_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok_s;
    int c;
    start_tx(8'($urandom), ok_s);
    c = 1;
    while (tx_error !== 1'b1 && c < 10000) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (!ok_s || c !== ERR_AT) begin
      n_bad++;
      $display("FAIL timeout_cycle: error at cycle %0d, want %0d", c, ERR_AT);
    end
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL timeout_error_cycle: clk_oe,data_oe,ready got %b, want 000",
               {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
    @(negedge clk);
    n_vec++;
    if ({tx_ready, tx_error, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL timeout_after: ready,error,busy got %b, want 100", {tx_ready, tx_error, busy});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [9:0] got;
    logic [7:0] b;
    bit ok_s, ok_d, ok_w;
    int d0, e0, i0;
    b  = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
    fork
      begin
        start_tx(b, ok_s);
        // A request while busy must be dropped, not queued.
        repeat (200) @(negedge clk);
        tx_data  = ~b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      device_xfer(1'b0, 1'b1, 0, got, ok_d);
    join
    wait_end(d0 + e0, ok_w);
    repeat (60) @(negedge clk);
    n_vec++;
    if ({ok_s, ok_d, ok_w} !== 3'b111 || got !== exp_frame(b)) begin
      n_bad++;
      $display("FAIL glitch_frame: got %b, want %b (flags %b)", got, exp_frame(b), {ok_s, ok_d, ok_w});
    end
    n_vec++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || inh_cnt - i0 !== 1) begin
      n_bad++;
      $display("FAIL glitch_pulses: done %0d err %0d inhibits %0d, want 1 0 1",
               done_cnt - d0, err_cnt - e0, inh_cnt - i0);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    bit ok_s, ok_d, ok_w;
    int d0, e0;
    fork
      start_tx(8'($urandom), ok_s);
      device_xfer(1'b0, 1'b0, 5, got, ok_d);
    join
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ok_s, ok_d, ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 6'b110001) begin
      n_bad++;
      $display("FAIL midreset_state: flags,clk_oe,data_oe,busy,ready got %b, want 110001",
               {ok_s, ok_d, ps2_clk_oe, ps2_data_oe, busy, tx_ready});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      start_tx(8'hFF, ok_s);
      device_xfer(1'b0, 1'b0, 0, got, ok_d);
    join
    wait_end(d0 + e0, ok_w);
    n_vec++;
    if ({ok_s, ok_d, ok_w} !== 3'b111 || got !== exp_frame(8'hFF)) begin
      n_bad++;
      $display("FAIL midreset_ff_frame: got %b, want %b (flags %b)",
               got, exp_frame(8'hFF), {ok_s, ok_d, ok_w});
    end
    n_vec++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_bad++;
      $display("FAIL midreset_ff_pulses: done %0d err %0d, want 1 and 0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_ack_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
